// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status into hazard_ctrl, stall/flush/redirect controls back out.
// master = pipeline side driving hazard status, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_memread;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_branch;
  logic                  ex_jalr;
  logic                  ex_bp_taken;
  logic                  ex_taken;
  logic                  icache_stall;
  logic                  dcache_stall;
  logic                  pc_stall;
  logic                  ifid_stall;
  logic                  ifid_flush;
  logic                  idex_stall;
  logic                  idex_flush;
  logic [1:0]            redirect_sel;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    output ex_memread, ex_rd_addr, ex_branch, ex_jalr, ex_bp_taken, ex_taken,
    output icache_stall, dcache_stall,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, redirect_sel
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    input  ex_memread, ex_rd_addr, ex_branch, ex_jalr, ex_bp_taken, ex_taken,
    input  icache_stall, dcache_stall,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, redirect_sel
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / mispredict hazard control with cache-freeze redirect hold; controls are combinational (0 cycles).
// Define HAZARD_PERF_EN to add saturating perf counters perf_stall_cyc, perf_mispred, perf_lu.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_mispred,
  output logic [CNT_W-1:0] perf_lu
`endif
);

  typedef enum logic [1:0] {RUN, FROZEN, FROZEN_REDIR} state_t;

  state_t     state_q, state_d;
  logic [1:0] pending_q, pending_d;

  logic       freeze, mispred, lu, lu_bubble;
  logic [1:0] sel;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic [1:0] redirect_sel;

  assign freeze  = hz.icache_stall | hz.dcache_stall;
  assign mispred = hz.ex_jalr | (hz.ex_branch & (hz.ex_taken != hz.ex_bp_taken));
  assign sel     = hz.ex_jalr ? 2'd3 : (hz.ex_taken ? 2'd1 : 2'd2);
  assign lu      = hz.ex_memread & (hz.ex_rd_addr != {REG_ADDR_W{1'b0}})
                 & ((hz.id_use_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr))
                  | (hz.id_use_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    redirect_sel = 2'd0;
    lu_bubble    = 1'b0;

    case (state_q)
      FROZEN_REDIR: begin
        if (freeze) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
        end else begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          redirect_sel = pending_q;
          pending_d    = 2'd0;
          state_d      = RUN;
        end
      end
      default: begin
        if (freeze) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          // Only RUN captures a mispredict; while frozen the EX stage is not advancing.
          if (state_q == RUN && mispred) begin
            pending_d = sel;
            state_d   = FROZEN_REDIR;
          end else begin
            state_d   = FROZEN;
          end
        end else begin
          state_d = RUN;
          if (mispred) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_sel = sel;
          end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            lu_bubble  = 1'b1;
          end
        end
      end
    endcase

    if (rst) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_flush   = 1'b0;
      redirect_sel = 2'd0;
      lu_bubble    = 1'b0;
    end

    // A held register must never also be cleared in the same cycle.
    ifid_flush = ifid_flush & ~ifid_stall;
    idex_flush = idex_flush & ~idex_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pending_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.ifid_stall   = ifid_stall;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_stall   = idex_stall;
  assign hz.idex_flush   = idex_flush;
  assign hz.redirect_sel = redirect_sel;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, mispred_cnt_q, lu_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
      lu_cnt_q      <= '0;
    end else begin
      if (pc_stall && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((redirect_sel != 2'd0) && !(&mispred_cnt_q))
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
      if (lu_bubble && !(&lu_cnt_q))
        lu_cnt_q <= lu_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cyc = stall_cnt_q;
  assign perf_mispred   = mispred_cnt_q;
  assign perf_lu        = lu_cnt_q;
`endif

endmodule
